// File: rtl/cache_2way.sv
`default_nettype none
// ============================================================================
//  Module      : cache_2way
//  Description : Two-way set-associative, write-back, write-allocate data
//                cache with one LRU bit per set. The processor side is
//                word-addressed (32-bit words) and the memory side moves
//                whole 128-bit lines. SET_BITS selects 2^SET_BITS sets
//                (legal range 1..6).
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_2way #(
    parameter int SET_BITS    = 2,
    parameter int TAG_WIDTH   = 28 - SET_BITS,
    parameter int BLOCK_WIDTH = 128,
    parameter int WORD_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   proc_reset,
    input  logic                   proc_read,
    input  logic                   proc_write,
    input  logic [29:0]            proc_addr,
    input  logic [WORD_WIDTH-1:0]  proc_wdata,
    output logic                   proc_stall,
    output logic [WORD_WIDTH-1:0]  proc_rdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [27:0]            mem_addr,
    input  logic [BLOCK_WIDTH-1:0] mem_rdata,
    output logic [BLOCK_WIDTH-1:0] mem_wdata,
    input  logic                   mem_ready
);

    localparam int NUM_SETS = 1 << SET_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_FETCH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Per-way line storage; the first index is the way, the second the set.
    logic                   r_valid [2][NUM_SETS];
    logic                   r_dirty [2][NUM_SETS];
    logic [TAG_WIDTH-1:0]   r_tag   [2][NUM_SETS];
    logic [BLOCK_WIDTH-1:0] r_data  [2][NUM_SETS];
    // One bit per set naming the least-recently-used way.
    logic [NUM_SETS-1:0]    r_lru;
    // Way chosen for replacement on the miss cycle; held through WB/FETCH.
    logic                   r_victim;

    logic [SET_BITS-1:0]    w_index;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic [1:0]             w_offset;
    logic                   w_req;
    logic                   w_hit0;
    logic                   w_hit1;
    logic                   w_hit;
    logic                   w_hit_way;
    logic [BLOCK_WIDTH-1:0] w_hit_line;
    logic [WORD_WIDTH-1:0]  w_hit_word;
    logic                   w_victim_pick;
    logic                   w_victim_wb;
    logic [TAG_WIDTH-1:0]   w_victim_tag;
    logic [BLOCK_WIDTH-1:0] w_victim_line;
    logic [BLOCK_WIDTH-1:0] w_fill_line;
    logic                   w_idle_hit;
    logic                   w_idle_miss;

    // Replace one word of a line at the given word offset.
    function automatic logic [BLOCK_WIDTH-1:0] f_merge(
        input logic [BLOCK_WIDTH-1:0] line,
        input logic [1:0]             off,
        input logic [WORD_WIDTH-1:0]  word
    );
        logic [BLOCK_WIDTH-1:0] merged;
        merged = line;
        merged[{off, 5'd0} +: WORD_WIDTH] = word;
        return merged;
    endfunction

    // Address fields.
    assign w_index  = proc_addr[SET_BITS+1:2];
    assign w_tag    = proc_addr[29:SET_BITS+2];
    assign w_offset = proc_addr[1:0];
    assign w_req    = proc_read | proc_write;

    // Tag compare on both ways; should both ever match, way 0 wins.
    assign w_hit0     = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
    assign w_hit1     = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_way  = ~w_hit0;
    assign w_hit_line = r_data[w_hit_way][w_index];
    assign w_hit_word = w_hit_line[{w_offset, 5'd0} +: WORD_WIDTH];

    assign w_idle_hit  = (r_state == S_IDLE) && w_req && w_hit;
    assign w_idle_miss = (r_state == S_IDLE) && w_req && !w_hit;

    // Replacement choice: an empty way first (way 0 preferred), else the LRU way.
    assign w_victim_pick = !r_valid[0][w_index] ? 1'b0 :
                           !r_valid[1][w_index] ? 1'b1 :
                           r_lru[w_index];
    assign w_victim_wb   = r_valid[w_victim_pick][w_index] && r_dirty[w_victim_pick][w_index];

    // Latched victim line, presented to memory while writing back.
    assign w_victim_tag  = r_tag[r_victim][w_index];
    assign w_victim_line = r_data[r_victim][w_index];

    // Incoming line, with the pending store folded in for write misses.
    assign w_fill_line = proc_write ? f_merge(mem_rdata, w_offset, proc_wdata) : mem_rdata;

    // Processor and memory side outputs decoded from state and lookup.
    always_comb begin
        proc_stall = !((r_state == S_IDLE) && w_hit);
        proc_rdata = w_hit ? w_hit_word : '0;
        mem_read   = (r_state == S_FETCH);
        mem_write  = (r_state == S_WB);
        mem_addr   = proc_addr[29:2];
        mem_wdata  = '0;
        if (r_state == S_WB) begin
            mem_addr  = {w_victim_tag, w_index};
            mem_wdata = w_victim_line;
        end
    end

    // Next-state logic for the miss handling sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_idle_miss) begin
                    w_state_next = w_victim_wb ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register and victim latch; the victim is captured only on the miss cycle.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state  <= S_IDLE;
            r_victim <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_idle_miss) begin
                r_victim <= w_victim_pick;
            end
        end
    end

    // Line storage: store hits merge and mark dirty, fills install the fetched line.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < 2; w++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_tag[w][s]   <= '0;
                    r_data[w][s]  <= '0;
                end
            end
            r_lru <= '0;
        end else if (w_idle_hit) begin
            r_lru[w_index] <= ~w_hit_way;
            if (proc_write) begin
                r_data[w_hit_way][w_index]  <= f_merge(w_hit_line, w_offset, proc_wdata);
                r_dirty[w_hit_way][w_index] <= 1'b1;
            end
        end else if ((r_state == S_FETCH) && mem_ready) begin
            r_data[r_victim][w_index]  <= w_fill_line;
            r_valid[r_victim][w_index] <= 1'b1;
            r_tag[r_victim][w_index]   <= w_tag;
            r_dirty[r_victim][w_index] <= proc_write;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_2way.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_2way
//  Description : Self-checking bench for cache_2way. A transaction-level
//                model (per-set ways + LRU bit, plus a backing memory map)
//                predicts every output each cycle; a few literal values pin
//                the model itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_2way;

    localparam int SB = 2;
    localparam int NS = 4;
    localparam int TW = 26;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic [127:0] mem_wdata;
    logic         mem_ready;

    always #5 clk = ~clk;

    cache_2way #(.SET_BITS(SB)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready)
    );

    // Reference model state
    logic          mvalid [NS][2];
    logic          mdirty [NS][2];
    logic [TW-1:0] mtag   [NS][2];
    logic [127:0]  mdata  [NS][2];
    logic          mlru   [NS];
    logic [127:0]  mem_model [logic [27:0]];

    // Expected outputs for the current cycle
    logic         chk_en = 1'b0;
    logic         exp_stall, exp_mr, exp_mw;
    logic [31:0]  exp_rdata;
    logic [27:0]  exp_maddr;
    logic [127:0] exp_mwd;

    int n_chk = 0;
    int n_pass = 0;
    int rd_cnt = 0, wr_cnt = 0, stall_cnt = 0;
    logic [27:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endfunction

    // Per-cycle comparison against the model, plus transfer bookkeeping
    always @(negedge clk) begin
        if (chk_en) begin
            chk("proc_stall", proc_stall, exp_stall);
            chk("proc_rdata", proc_rdata, exp_rdata);
            chk("mem_read",   mem_read,   exp_mr);
            chk("mem_write",  mem_write,  exp_mw);
            chk("mem_addr",   mem_addr,   exp_maddr);
            chk("mem_wdata",  mem_wdata,  exp_mwd);
        end
        if (mem_read === 1'b1 && mem_ready === 1'b1) begin
            rd_cnt++;
            last_rd_addr = mem_addr;
        end
        if (mem_write === 1'b1 && mem_ready === 1'b1) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
        if (proc_stall === 1'b1) stall_cnt++;
    end

    function automatic logic [31:0] word_of(input logic [127:0] l, input logic [1:0] off);
        return l[int'(off)*32 +: 32];
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] l, input logic [1:0] off, input logic [31:0] w);
        logic [127:0] m;
        m = l;
        m[int'(off)*32 +: 32] = w;
        return m;
    endfunction

    // Backing memory: untouched lines have a recognisable per-address pattern
    function automatic logic [127:0] line_of(input logic [27:0] la);
        if (mem_model.exists(la)) return mem_model[la];
        return {4'h4, la, 4'h3, la, 4'h2, la, 4'h1, la};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int find(input logic [29:0] a);
        int s;
        s = int'(a[3:2]);
        if (mvalid[s][0] && mtag[s][0] == a[29:4]) return 0;
        if (mvalid[s][1] && mtag[s][1] == a[29:4]) return 1;
        return -1;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < 2; w++) begin
                mvalid[s][w] = 1'b0;
                mdirty[s][w] = 1'b0;
                mtag[s][w]   = '0;
                mdata[s][w]  = '0;
            end
            mlru[s] = 1'b0;
        end
    endfunction

    function automatic void set_exp(input logic st, input logic [31:0] rd, input logic mr,
                                    input logic mw, input logic [27:0] ma, input logic [127:0] wd);
        exp_stall = st;
        exp_rdata = rd;
        exp_mr    = mr;
        exp_mw    = mw;
        exp_maddr = ma;
        exp_mwd   = wd;
    endfunction

    function automatic void idle_exp(input logic [29:0] a);
        int w;
        int s;
        w = find(a);
        s = int'(a[3:2]);
        if (w < 0) set_exp(1'b1, '0, 1'b0, 1'b0, a[29:2], '0);
        else       set_exp(1'b0, word_of(mdata[s][w], a[1:0]), 1'b0, 1'b0, a[29:2], '0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [29:0] a);
        proc_read = 1'b0;
        proc_write = 1'b0;
        proc_addr = a;
        idle_exp(a);
        step();
    endtask

    task automatic probe(input string name, input logic [29:0] a, input logic st, input logic [31:0] rd);
        proc_read = 1'b0;
        proc_write = 1'b0;
        proc_addr = a;
        idle_exp(a);
        @(negedge clk);
        chk({name, "_stall"}, proc_stall, st);
        chk({name, "_rdata"}, proc_rdata, rd);
        @(posedge clk);
        #1;
    endtask

    // One processor request, including any write-back / fetch it triggers
    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                          input int lwb, input int lf, input bit drop, input bit hold);
        int s;
        int w;
        int v;
        logic [127:0] line;
        logic [27:0]  vaddr;
        s = int'(a[3:2]);
        proc_addr  = a;
        proc_wdata = wd;
        proc_read  = !wr;
        proc_write = wr;
        w = find(a);
        if (w >= 0) begin
            set_exp(1'b0, word_of(mdata[s][w], a[1:0]), 1'b0, 1'b0, a[29:2], '0);
            step();
            if (wr) begin
                mdata[s][w]  = merge(mdata[s][w], a[1:0], wd);
                mdirty[s][w] = 1'b1;
            end
            mlru[s] = (w == 0);
        end else begin
            set_exp(1'b1, '0, 1'b0, 1'b0, a[29:2], '0);
            v = !mvalid[s][0] ? 0 : !mvalid[s][1] ? 1 : int'(mlru[s]);
            step();
            if (drop) begin
                proc_read = 1'b0;
                proc_write = 1'b0;
            end
            if (mvalid[s][v] && mdirty[s][v]) begin
                vaddr = {mtag[s][v], a[3:2]};
                for (int k = 0; k < lwb; k++) begin
                    mem_ready = (k == lwb - 1);
                    set_exp(1'b1, '0, 1'b0, 1'b1, vaddr, mdata[s][v]);
                    step();
                end
                mem_model[vaddr] = mdata[s][v];
            end
            line = line_of(a[29:2]);
            for (int k = 0; k < lf; k++) begin
                mem_ready = (k == lf - 1);
                mem_rdata = mem_ready ? line : rnd128();
                set_exp(1'b1, '0, 1'b1, 1'b0, a[29:2], '0);
                step();
            end
            mem_ready = hold;
            mem_rdata = rnd128();
            mvalid[s][v] = 1'b1;
            mtag[s][v]   = a[29:4];
            mdirty[s][v] = wr && !drop;
            mdata[s][v]  = (wr && !drop) ? merge(line, a[1:0], wd) : line;
            set_exp(1'b0, word_of(mdata[s][v], a[1:0]), 1'b0, 1'b0, a[29:2], '0);
            step();
            mem_ready = 1'b0;
            if (!drop) mlru[s] = (v == 0);
        end
        proc_read = 1'b0;
        proc_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int w0;
        int s0;
        logic [29:0] a;
        int r;

        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        model_clear();

        // Reset state
        step();
        idle_exp(30'h0);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_stall",  proc_stall, 1'b1);
        chk("rst_rdata",  proc_rdata, 32'h0);
        chk("rst_mread",  mem_read,   1'b0);
        chk("rst_mwrite", mem_write,  1'b0);
        chk("rst_mwdata", mem_wdata,  128'h0);
        @(posedge clk);
        #1;
        proc_reset = 1'b0;

        // Read miss to set 0, then hit on the filled line
        mem_model[28'h4] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        r0 = rd_cnt;
        access(1'b0, 30'h10, 32'h0, 1, 1, 1'b0, 1'b0);
        chk("t1_fetch_addr", last_rd_addr, 28'h4);
        chk("t1_fetch_cnt", rd_cnt - r0, 1);
        probe("t1", 30'h10, 1'b0, 32'hAAAA_AAAA);

        // Write hit: no stall, no traffic
        s0 = stall_cnt;
        w0 = wr_cnt;
        access(1'b1, 30'h10, 32'hCAFE_F00D, 1, 1, 1'b0, 1'b0);
        chk("t2_nostall", stall_cnt - s0, 0);
        probe("t2", 30'h10, 1'b0, 32'hCAFE_F00D);
        chk("t2_no_rd", rd_cnt - r0, 1);
        chk("t2_no_wr", wr_cnt - w0, 0);

        // Two tags coexist in set 1; a third evicts the LRU one
        r0 = rd_cnt;
        access(1'b0, 30'h14, 32'h0, 1, 2, 1'b0, 1'b0);
        access(1'b0, 30'h24, 32'h0, 1, 1, 1'b0, 1'b0);
        access(1'b0, 30'h14, 32'h0, 1, 1, 1'b0, 1'b0);
        chk("t3_two_fills", rd_cnt - r0, 2);
        access(1'b0, 30'h34, 32'h0, 1, 1, 1'b0, 1'b1);
        chk("t3_third_fill", rd_cnt - r0, 3);
        probe("t3_keep", 30'h14, 1'b0, 32'h1000_0005);
        probe("t3_evict", 30'h24, 1'b1, 32'h0);
        probe("t3_new", 30'h34, 1'b0, 32'h1000_000D);

        // Dirty LRU victim in set 2 is written back before the fetch
        access(1'b1, 30'h18, 32'h5555_AAAA, 1, 1, 1'b0, 1'b0);
        access(1'b0, 30'h28, 32'h0, 1, 1, 1'b0, 1'b0);
        w0 = wr_cnt;
        access(1'b0, 30'h38, 32'h0, 2, 2, 1'b0, 1'b0);
        chk("t4_wb_cnt", wr_cnt - w0, 1);
        chk("t4_wb_addr", last_wr_addr, 28'h6);
        chk("t4_wb_data", last_wr_data, {32'h4000_0006, 32'h3000_0006, 32'h2000_0006, 32'h5555_AAAA});

        // Write miss, three fetch cycles, store merged at offset 2
        s0 = stall_cnt;
        access(1'b1, 30'h5E, 32'h1234_5678, 1, 3, 1'b0, 1'b0);
        chk("t5_stall_cycles", stall_cnt - s0, 4);
        probe("t5_merged", 30'h5E, 1'b0, 32'h1234_5678);
        probe("t5_other", 30'h5C, 1'b0, 32'h1000_0017);
        access(1'b0, 30'h6C, 32'h0, 1, 1, 1'b0, 1'b0);
        w0 = wr_cnt;
        access(1'b0, 30'h7C, 32'h0, 1, 1, 1'b0, 1'b0);
        chk("t5_dirty_wb", wr_cnt - w0, 1);
        chk("t5_wb_addr", last_wr_addr, 28'h17);
        chk("t5_wb_data", last_wr_data, {32'h4000_0017, 32'h1234_5678, 32'h2000_0017, 32'h1000_0017});

        // Reset during FETCH
        proc_addr = 30'h70;
        proc_read = 1'b1;
        set_exp(1'b1, '0, 1'b0, 1'b0, 28'h1C, '0);
        step();
        set_exp(1'b1, '0, 1'b1, 1'b0, 28'h1C, '0);
        proc_reset = 1'b1;
        step();
        proc_reset = 1'b0;
        proc_read = 1'b0;
        model_clear();
        idle_exp(30'h70);
        @(negedge clk);
        chk("t6_mread_drop", mem_read, 1'b0);
        chk("t6_stall", proc_stall, 1'b1);
        @(posedge clk);
        #1;
        probe("t6_cleared", 30'h10, 1'b1, 32'h0);
        r0 = rd_cnt;
        access(1'b0, 30'h70, 32'h0, 1, 1, 1'b0, 1'b0);
        chk("t6_refetch", rd_cnt - r0, 1);
        access(1'b0, 30'h10, 32'h0, 1, 1, 1'b0, 1'b0);
        probe("t6_discard", 30'h10, 1'b0, 32'hAAAA_AAAA);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            a = (30'($urandom_range(0, 3)) << 4) | (30'($urandom_range(0, 3)) << 2) | 30'($urandom_range(0, 3));
            r = int'($urandom_range(0, 99));
            if (r < 20) begin
                idle(a);
            end else begin
                access(($urandom_range(0, 1) == 1), a, $urandom,
                       int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_2way.md
# cache_2way

Two-way set-associative, write-back, write-allocate data cache with one LRU bit per set and a parametrised set count. Drop-in successor to the direct-mapped cache, with identical processor and memory ports. Sits between the core's data port (word-addressed, 32-bit) and the 128-bit line-wide memory interface. Default capacity (4 sets × 2 ways × 4 words) equals the previous block's capacity, but conflicting lines no longer thrash.

## Interface
- SET_BITS, 2: log2 of set count; legal range 1..6. Set count is 2^SET_BITS.
- TAG_WIDTH, 28-SET_BITS: derived; not to be overridden.
- BLOCK_WIDTH, 128: line width (4 words); fixed.
- WORD_WIDTH, 32: word width; fixed.
- Clock is `clk`. Reset is `proc_reset`, synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- proc_reset  in  1  synchronous active-high reset
- proc_read  in  1  read request
- proc_write  in  1  write request; wins if asserted together with proc_read
- proc_addr  in  30  word address: [1:0] word offset, [SET_BITS+1:2] set index, [29:SET_BITS+2] tag
- proc_wdata  in  32  write data
- proc_stall  out  1  1 unless state==IDLE and the current address hits
- proc_rdata  out  32  selected word of the hitting way; 0 when no way hits
- mem_read  out  1  high exactly while state==FETCH
- mem_write  out  1  high exactly while state==WB
- mem_addr  out  28  {victim tag, index} in WB; proc_addr[29:2] otherwise
- mem_rdata  in  128  fill data; valid in the cycle mem_ready is high
- mem_wdata  out  128  victim line in WB; 0 otherwise
- mem_ready  in  1  memory completion strobe (one or more cycles)

## Operation
- Storage per set: 2 ways × {valid, dirty, tag, 128-bit data}, plus lru bit (index of the least-recently-used way).
- Hit: a way is valid and its tag is equal. Both ways hitting is illegal; the block asserts way 0.
- States:
  - IDLE: on request + hit, stall=0.
    - Write: merges the word at the offset into the hit way and sets dirty=1.
    - Read: leaves storage unchanged.
    - Either request sets lru = other way.
  - IDLE: on request + miss, stall=1.
    - Victim = first invalid way (way 0 preferred), else way[lru]. Victim is latched into a register.
    - Goes to WB if the victim is valid and dirty, else to FETCH.
  - IDLE: no request → stays IDLE, no storage change.
  - WB: holds mem_write, mem_addr, mem_wdata from the latched victim. On mem_ready → FETCH.
  - FETCH: holds mem_read and mem_addr=proc_addr[29:2]. On mem_ready:
    - Writes mem_rdata into the victim way with valid=1 and tag=proc tag.
    - If proc_write: merges proc_wdata at the offset and sets dirty=1; else dirty=0.
    - Goes to IDLE.
- After a fill, the following IDLE cycle is a hit. It releases the stall, updates lru, and re-applies any write (idempotent).
- The processor holds proc_addr, proc_read, proc_write, proc_wdata stable while proc_stall=1.
- Request dropped mid-miss: WB/FETCH still complete. The fill is clean (dirty=0).

## Timing
- Reset (next edge with proc_reset=1):
  - State goes to IDLE.
  - All valid, dirty and lru bits, tags and data go to 0.
  - Outputs after reset: mem_read=0, mem_write=0, mem_wdata=0, proc_stall=1 (no hit possible), proc_rdata=0.
- Reset mid-WB/FETCH: aborts immediately and drops mem_read/mem_write the next cycle. Dirty data is discarded.
- Hit latency is 0 cycles: proc_stall=0 combinationally in the request cycle, and the write commits on that edge.
- Clean miss, mem_ready after N FETCH cycles: stall for 1 (IDLE detect) + N cycles, then proc_stall=0.
- Dirty miss: 1 + N_wb + N_fetch stall cycles.
- mem_ready is sampled only in WB/FETCH. mem_ready held high longer than one cycle causes no duplicate transfer.
- Victim selection and lru are evaluated on the IDLE miss cycle only. Victim is stable through WB/FETCH.

## Test plan
- Reset, then read addr 0x0000_0010 (set 0) → mem_read with mem_addr=0x000_0004. Supply mem_rdata=128'hD_C_B_A words with mem_ready for 1 cycle → next cycle proc_stall=0, proc_rdata=A.
- Write 0xCAFE_F00D to a resident word → stall=0 same cycle. Re-read returns 0xCAFE_F00D with no memory traffic.
- Two tags in the same set (tag 1 to way 0, tag 2 to way 1), both read, then read tag 1 again → both resident, no memory traffic. Read tag 3 → way 1 (LRU) evicted; tag 1 still hits.
- Dirty way 0, make it LRU, miss in that set → mem_write with mem_addr={old tag, index} and mem_wdata=dirty line, then mem_read. Final line clean.
- Write miss with mem_ready delayed 3 cycles → 4 stall cycles. Line holds mem_rdata with proc_wdata merged at offset 2, dirty=1.
- Assert proc_reset during FETCH → mem_read=0 next cycle. Re-access to the same address misses again.
